// File: rtl/step_counter_if.sv
// step_counter_if
//   Bundles the control, configuration and result signals of step_counter.
//   master : the client that drives the controls and reads count/tc.
//   slave  : the counter itself.
//
//   Signals
//     en     : advance by one step this cycle
//     ld     : synchronous load of ld_val (wins over en)
//     ld_val : load value, clamped to limit
//     incr   : unsigned step size
//     limit  : highest legal count, range is 0..limit
//     dir    : 0 = up, 1 = down
//     sat    : 0 = wrap modulo (limit+1), 1 = saturate at 0/limit
//     count  : registered count
//     tc     : registered one-cycle terminal-count pulse
//
//   Handshake: there is no backpressure. en/ld act as per-cycle qualifiers
//   sampled on every rising clk edge; count/tc reflect that edge one cycle
//   later and are always valid outside reset.
interface step_counter_if #(
  parameter int WIDTH = 9
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] incr;
  logic [WIDTH-1:0] limit;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, ld, ld_val, incr, limit, dir, sat,
    input  count, tc
  );

  modport slave (
    input  en, ld, ld_val, incr, limit, dir, sat,
    output count, tc
  );
endinterface

// File: rtl/step_counter.sv
// step_counter
//   Programmable-step up/down counter used as a ROM address / phase
//   generator. The step sets output frequency, the limit sets the table
//   length. Supports wrap or saturate at the range ends, a synchronous
//   clamped load and a registered terminal-count pulse.
//
//   Ports
//     clk : system clock, all state changes on posedge
//     rst : asynchronous, active-low reset (count = 0, tc = 0)
//     bus : step_counter_if.slave (controls in, count/tc out)
module step_counter #(
  parameter int WIDTH = 9
) (
  input  logic         clk,
  input  logic         rst,
  step_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_tc;

  // All boundary arithmetic is carried one bit wider so that limit+1 and
  // count+incr never overflow.
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] mod_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] wrap_up;
  logic [WIDTH:0] wrap_dn;

  assign lim_x   = {1'b0, bus.limit};
  assign mod_x   = lim_x + (WIDTH+1)'(1);
  assign sum     = {1'b0, count_q} + {1'b0, bus.incr};
  assign wrap_up = sum - mod_x;
  // May underflow when incr exceeds count+limit+1; the wrapped value is then
  // above limit and gets clamped to limit below.
  assign wrap_dn = {1'b0, count_q} + mod_x - {1'b0, bus.incr};

  always_comb begin
    nxt_count = count_q;
    nxt_tc    = 1'b0;
    if (bus.ld) begin
      nxt_count = (bus.ld_val > bus.limit) ? bus.limit : bus.ld_val;
    end else if (bus.en) begin
      if (count_q > bus.limit) begin
        // Limit was lowered beneath the current count: pull back into range.
        nxt_tc    = 1'b1;
        nxt_count = (!bus.dir && !bus.sat) ? '0 : bus.limit;
      end else if (!bus.dir) begin
        if (sum <= lim_x) begin
          nxt_count = sum[WIDTH-1:0];
        end else if (!bus.sat) begin
          nxt_tc    = 1'b1;
          // A step larger than the whole range cannot land in range.
          nxt_count = (wrap_up > lim_x) ? '0 : wrap_up[WIDTH-1:0];
        end else begin
          nxt_count = bus.limit;
          nxt_tc    = (count_q != bus.limit);
        end
      end else begin
        if (count_q >= bus.incr) begin
          nxt_count = count_q - bus.incr;
        end else if (!bus.sat) begin
          nxt_tc    = 1'b1;
          nxt_count = (wrap_dn > lim_x) ? bus.limit : wrap_dn[WIDTH-1:0];
        end else begin
          nxt_count = '0;
          nxt_tc    = (count_q != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= nxt_count;
      tc_q    <= nxt_tc;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule
